// File: rtl/swap_sequencer.sv
// Command sequencer that drives an external 3-port register file for
// write, read, nop and two-register swap. Every output comes straight from a flop.
module swap_sequencer #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data_a,
    output logic [DW-1:0] rsp_data_b,
    output logic          done,
    output logic [AW-1:0] A1,
    output logic [AW-1:0] A2,
    output logic [AW-1:0] A3,
    output logic          WE,
    output logic [DW-1:0] WD3,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2
);

    typedef enum logic [2:0] {
        IDLE, WRITE, READ, RESP, SWAP_RD, SWAP_WA, SWAP_WB
    } state_e;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [AW-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic [DW-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wd3_q       <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            wd3_q       <= wd3_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    // Outputs are registered, so each branch computes what the *next* cycle shows.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        rsp_valid_d = 1'b0;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        wd3_d       = wd3_q;
        tmp_a_d     = tmp_a_q;
        tmp_b_d     = tmp_b_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    addr_a_d = cmd_addr_a;
                    addr_b_d = cmd_addr_b;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d = WRITE;
                            a3_d    = cmd_addr_a;
                            wd3_d   = cmd_wdata;
                            we_d    = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_SWAP: begin
                            // Swapping a register with itself is a no-op completion.
                            if (cmd_addr_a == cmd_addr_b) begin
                                state_d = RESP;
                                done_d  = 1'b1;
                            end else begin
                                state_d = SWAP_RD;
                                a1_d    = cmd_addr_a;
                                a2_d    = cmd_addr_b;
                            end
                        end
                        OP_READ: begin
                            state_d = READ;
                            a1_d    = cmd_addr_a;
                            a2_d    = cmd_addr_b;
                        end
                        default: begin
                            state_d = RESP;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                state_d     = RESP;
                rsp_a_d     = RD1;
                rsp_b_d     = RD2;
                rsp_valid_d = 1'b1;
                done_d      = 1'b1;
            end
            RESP: state_d = IDLE;
            SWAP_RD: begin
                state_d = SWAP_WA;
                tmp_a_d = RD1;
                tmp_b_d = RD2;
                a3_d    = addr_a_q;
                wd3_d   = RD2;
                we_d    = 1'b1;
            end
            SWAP_WA: begin
                state_d = SWAP_WB;
                a3_d    = addr_b_q;
                wd3_d   = tmp_a_q;
                we_d    = 1'b1;
                done_d  = 1'b1;
            end
            SWAP_WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    assign cmd_ready  = ready_q;
    assign WE         = we_q;
    assign done       = done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_a_q;
    assign rsp_data_b = rsp_b_q;
    assign A1         = a1_q;
    assign A2         = a2_q;
    assign A3         = a3_q;
    assign WD3        = wd3_q;

endmodule
